// File: rtl/in_switch.sv
// Packet-level 1-to-3 AXI-Stream demultiplexer with a 2-entry steering buffer.
// Only the buffer head drives a master port; idle ports carry all-zero data for the downstream OR-merge.
module in_switch #(
  parameter int DWIDTH = 128,
  parameter int LASTW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [LASTW-1:0]  s_axis_tlast,
  input  logic [1:0]        dest_sel,
  input  logic              weight_switch,
  output logic [DWIDTH-1:0] m_axis_tdata_0,
  output logic              m_axis_tvalid_0,
  input  logic              m_axis_tready_0,
  output logic [LASTW-1:0]  m_axis_tlast_0,
  output logic [DWIDTH-1:0] m_axis_tdata_1,
  output logic              m_axis_tvalid_1,
  input  logic              m_axis_tready_1,
  output logic [LASTW-1:0]  m_axis_tlast_1,
  output logic [DWIDTH-1:0] m_axis_tdata_2,
  output logic              m_axis_tvalid_2,
  input  logic              m_axis_tready_2,
  output logic [LASTW-1:0]  m_axis_tlast_2,
  output logic              weight_switch_out,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]        dest;
    logic              ws;
    logic [DWIDTH-1:0] data;
    logic [LASTW-1:0]  last;
  } entry_t;

  // Handshake: a transfer happens on any edge where valid and ready are both high;
  // valid never waits on ready, and a raised master valid holds with stable data until its pop.
  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_dest;
  logic        r_ws;
  entry_t      r_mem [2];
  logic        r_wptr;
  logic        r_rptr;
  logic [1:0]  r_count;
  logic        r_tready;

  logic        w_accept;
  logic        w_last;
  logic [1:0]  w_cur_dest;
  logic        w_cur_ws;
  logic        w_push;
  logic        w_pop;
  logic        w_head_vld;
  entry_t      w_head;
  entry_t      w_new;
  logic [1:0]  w_count_next;

  assign w_accept   = s_axis_tvalid & r_tready;
  assign w_last     = |s_axis_tlast;

  // The first beat of a packet steers itself from the live sideband inputs.
  assign w_cur_dest = (r_state == ST_IDLE) ? dest_sel : r_dest;
  assign w_cur_ws   = (r_state == ST_IDLE) ? weight_switch : r_ws;
  assign w_push     = w_accept & (w_cur_dest != 2'd3);

  assign w_new      = '{dest: w_cur_dest, ws: w_cur_ws, data: s_axis_tdata, last: s_axis_tlast};
  assign w_head     = r_mem[r_rptr];
  assign w_head_vld = (r_count != 2'd0);

  always_comb begin
    w_pop = 1'b0;
    if (w_head_vld) begin
      case (w_head.dest)
        2'd0:    w_pop = m_axis_tready_0;
        2'd1:    w_pop = m_axis_tready_1;
        2'd2:    w_pop = m_axis_tready_2;
        default: w_pop = 1'b0;
      endcase
    end
  end

  assign w_count_next = r_count + 2'(w_push) - 2'(w_pop);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_last) begin
          w_state_next = (dest_sel == 2'd3) ? ST_DROP : ST_FWD;
        end
      end
      ST_FWD, ST_DROP: begin
        if (w_accept && w_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_dest  <= 2'd0;
      r_ws    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && w_accept) begin
        r_dest <= dest_sel;
        r_ws   <= weight_switch;
      end
    end
  end

  // Ready is registered from the post-edge occupancy, so a full buffer can never be overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
      r_tready <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_new;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count  <= w_count_next;
      r_tready <= (w_count_next < 2'd2);
    end
  end

  always_comb begin
    m_axis_tdata_0  = '0;
    m_axis_tvalid_0 = 1'b0;
    m_axis_tlast_0  = '0;
    m_axis_tdata_1  = '0;
    m_axis_tvalid_1 = 1'b0;
    m_axis_tlast_1  = '0;
    m_axis_tdata_2  = '0;
    m_axis_tvalid_2 = 1'b0;
    m_axis_tlast_2  = '0;
    if (w_head_vld) begin
      case (w_head.dest)
        2'd0: begin
          m_axis_tdata_0  = w_head.data;
          m_axis_tvalid_0 = 1'b1;
          m_axis_tlast_0  = w_head.last;
        end
        2'd1: begin
          m_axis_tdata_1  = w_head.data;
          m_axis_tvalid_1 = 1'b1;
          m_axis_tlast_1  = w_head.last;
        end
        2'd2: begin
          m_axis_tdata_2  = w_head.data;
          m_axis_tvalid_2 = 1'b1;
          m_axis_tlast_2  = w_head.last;
        end
        default: begin
          m_axis_tvalid_0 = 1'b0;
        end
      endcase
    end
  end

  assign weight_switch_out = w_head_vld & w_head.ws;
  assign s_axis_tready     = r_tready;
  assign o_dbg_state       = r_state;

endmodule

// File: doc/in_switch.md
# in_switch

Packet-level 1-to-3 AXI-Stream demultiplexer that feeds the three slave ports of the output merge stage. Each packet arriving on the single slave port is steered, whole, to one of three master ports selected by `dest_sel` at the packet's first beat, or dropped. Steering passes through a 2-entry buffer, so the block:
- runs at full throughput;
- guarantees that at most one master port is valid in any cycle;
- drives zero data on all idle ports, which the downstream OR-merge requires.

The per-packet `weight_switch` flag travels with the data.

## Interface
Parameters:
- `DWIDTH`, 128: data width of all streams.
- `LASTW`, 1: tlast width. End-of-packet is `|tlast`.

Ports:
- `clk`  in  1  Single clock; all logic is rising-edge.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `s_axis_tdata`  in  DWIDTH  Input data.
- `s_axis_tvalid`  in  1  Input valid.
- `s_axis_tready`  out  1  Input ready. Registered.
- `s_axis_tlast`  in  LASTW  Input last.
- `dest_sel`  in  2  Destination: 0/1/2 select port 0/1/2; 3 drops the packet. Sampled on the first beat only.
- `weight_switch`  in  1  Packet flag. Sampled on the first beat only.
- `m_axis_tdata_k`  out  DWIDTH  Output data for k = 0, 1, 2.
- `m_axis_tvalid_k`  out  1  Output valid for k = 0, 1, 2.
- `m_axis_tready_k`  in  1  Output ready for k = 0, 1, 2.
- `m_axis_tlast_k`  out  LASTW  Output last for k = 0, 1, 2.
- `weight_switch_out`  out  1  Flag of the buffer head entry; 0 when the buffer is empty.

## Operation
- Input accept: a beat is accepted when `s_axis_tvalid & s_axis_tready`.
- Packet FSM:
  - IDLE (reset state): on the first accepted beat, latch `dest` = `dest_sel` and `ws` = `weight_switch`.
    - If the beat also has `|tlast`, stay in IDLE (single-beat packet).
    - Otherwise go to FWD if `dest` is 0–2, or DROP if `dest` is 3.
  - FWD: each accepted beat uses the latched `dest`/`ws`. The beat with `|tlast` returns the FSM to IDLE.
  - DROP: accepted beats are discarded. The beat with `|tlast` returns the FSM to IDLE.
- `dest_sel` and `weight_switch` changes in FWD or DROP are ignored.
- The first beat of a packet steers itself, using `dest_sel`/`weight_switch` combinationally in IDLE.
- Buffer:
  - 2-entry FIFO of {dest, ws, tdata, tlast}.
  - Every accepted non-drop beat is pushed; dropped beats are never pushed.
  - `count` ranges 0..2.
- Output:
  - The head entry drives only port `head.dest`: `tvalid` = 1, data/last from the entry.
  - Every other port drives `tvalid` 0, `tdata` 0, `tlast` 0.
  - When the buffer is empty, all ports are 0.
- Pop: on `m_axis_tready_[head.dest]` while the head is valid. Ready inputs of non-head ports are ignored.
- Ready: `s_axis_tready` is registered. Next value is 1 iff the next `count` < 2, or the next count is 2 with a pop guaranteed (not required; a simple `count_next < 2` is acceptable).
  - DROP state is not exempt: with the buffer full it stalls like any other state.
- Order: beats leave in arrival order. A packet to port 1 queued behind a packet to port 0 waits (head-of-line blocking is intended).
- Reset (asserted at any time, including mid-packet):
  - FSM goes to IDLE; buffer is emptied.
  - All `m_axis_tvalid_k`, `m_axis_tdata_k`, `m_axis_tlast_k` and `weight_switch_out` are 0.
  - `s_axis_tready` is 0.
  - The partial packet is lost; the upstream is responsible for restarting it.

## Timing
- `s_axis_tready` rises on the first `clk` edge after `rst_n` deasserts.
- Latency: a beat accepted at edge N is valid on its port after edge N, when the buffer was empty or popped at N. Minimum latency is 1 cycle.
- Throughput: 1 beat/cycle sustained while the head port is ready every cycle.
- Simultaneous push and pop when `count` = 2: no push can occur because ready was 0.
- Simultaneous push and pop when `count` = 1: `count` stays 1.
- Once a master `tvalid` is asserted, it and its data stay stable until the pop (AXI rule).
- Port switch between packets: the last beat of port A is popped at edge N; the first beat of port B is valid after edge N. Zero bubble, and never two ports valid together.

## Test plan
- Reset release: `rst_n` low then high. All outputs are 0 during reset; `s_axis_tready` = 1 one cycle after release.
- Routing: 3 packets of 4 beats, `dest_sel` = 0, 1, 2, data 0x1..0xC, all readies 1.
  - Each packet appears on its port, in order, 1-cycle latency, no bubbles.
  - `m_axis_tlast_k` is set only on beats 0x4, 0x8, 0xC.
  - Idle ports stay at tdata 0.
- Drop and mid-packet change: packet 1 has `dest_sel` = 3 (3 beats); packet 2 has `dest_sel` = 1, with `dest_sel` toggled mid-packet.
  - No output for packet 1; all of packet 2 goes to port 1.
  - `s_axis_tready` stays 1 throughout.
- Backpressure: `m_axis_tready_0` = 0 for 5 cycles during a 6-beat packet.
  - `s_axis_tready` falls after 2 beats are buffered.
  - No data is lost or duplicated; resumes at 1 beat/cycle.
- Weight flag and single-beat packets: 1-beat packets alternating dest 2/0 with `weight_switch` 1/0.
  - `weight_switch_out` tracks each head entry.
  - Never two `m_axis_tvalid_k` high in the same cycle.
- Reset mid-packet: assert `rst_n` on beat 3 of 6.
  - Outputs are 0 immediately (asynchronous).
  - After release, a new packet with `dest_sel` = 2 routes correctly; stale beats never appear.
